ex_muldiv: RTL and testbench

Execute-stage multiply/divide unit with architectural HI/LO registers. It consumes the operation and operands the ID/EX pipeline register presents to EX, and performs MULT/MULTU in one cycle and DIV/DIVU as a 32-iteration restoring divider. While a division is in progress it requests a pipeline stall, and it returns HI/LO for MFHI/MFLO to the EX result mux. It sits beside the ALU inside EX, between the ID/EX register and the EX/MEM register.

---
 rtl/cpu_defs.sv | 41 ++++
 rtl/ex_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU types: machine word and decoded operation codes.
// Imported by every pipeline stage.
package cpu_defs;

  typedef logic [31:0] Word_t;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD,
    OP_ADDU,
    OP_SUB,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_LUI,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU,
    OP_MTHI,
    OP_MTLO,
    OP_MFHI,
    OP_MFLO,
    OP_LW,
    OP_SW,
    OP_BEQ,
    OP_BNE,
    OP_J,
    OP_JAL,
    OP_JR,
    OP_INVALID
  } Oper_t;

endpackage

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with HI/LO; 1-cycle MULT, 32-step restoring DIV.
// Ports: clk, rst (async low), ex_op/ex_reg1/ex_reg2, flush -> stall_req, result, hi, lo. Divider needs MULDIV_DIV_EN.
module ex_muldiv
  import cpu_defs::*;
(
  input  logic  clk,
  input  logic  rst,
  input  Oper_t ex_op,
  input  Word_t ex_reg1,
  input  Word_t ex_reg2,
  input  logic  flush,
  output logic  stall_req,
  output Word_t result,
  output Word_t hi,
  output Word_t lo
);

  logic is_mult;
  logic is_multu;
  logic is_div;
  logic is_divu;
  logic is_mthi;
  logic is_mtlo;
  logic is_mfhi;
  logic is_mflo;

  assign is_mult  = (ex_op == OP_MULT);
  assign is_multu = (ex_op == OP_MULTU);
  assign is_div   = (ex_op == OP_DIV);
  assign is_divu  = (ex_op == OP_DIVU);
  assign is_mthi  = (ex_op == OP_MTHI);
  assign is_mtlo  = (ex_op == OP_MTLO);
  assign is_mfhi  = (ex_op == OP_MFHI);
  assign is_mflo  = (ex_op == OP_MFLO);

  // Sign-extend only for MULT; the low 64 bits of
  // the 64x64 product are then the exact result.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  assign mul_a = {{32{is_mult & ex_reg1[31]}}, ex_reg1};
  assign mul_b = {{32{is_mult & ex_reg2[31]}}, ex_reg2};
  assign prod  = mul_a * mul_b;

  logic  div_wr;
  Word_t div_hi;
  Word_t div_lo;

`ifdef MULDIV_DIV_EN

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  div_state_t  state;
  logic [4:0]  cnt;
  Word_t       rem;
  Word_t       quo;
  Word_t       dvs;
  logic        neg_q;
  logic        neg_r;

  logic        div_start;
  logic        sgn1;
  logic        sgn2;
  Word_t       mag1;
  Word_t       mag2;
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;

  assign sgn1 = is_div & ex_reg1[31];
  assign sgn2 = is_div & ex_reg2[31];
  assign mag1 = sgn1 ? -ex_reg1 : ex_reg1;
  assign mag2 = sgn2 ? -ex_reg2 : ex_reg2;

  // Only IDLE may start: the DIV still held in
  // EX during DIV_DONE must not relaunch.
  assign div_start = (state == DIV_IDLE)
                   & (is_div | is_divu)
                   & (ex_reg2 != '0)
                   & ~flush;

  assign stall_req = rst & ~flush
                   & (div_start | (state == DIV_BUSY));

  // Remainder stays below the divisor, so 32
  // stored bits suffice; the shift needs 33.
  assign rem_sh  = {rem, quo[31]};
  assign rem_sub = rem_sh - {1'b0, dvs};

  assign div_wr = (state == DIV_DONE) & ~flush;
  assign div_lo = neg_q ? -quo : quo;
  assign div_hi = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (div_start) begin
            state <= DIV_BUSY;
            cnt   <= '0;
            rem   <= '0;
            quo   <= mag1;
            dvs   <= mag2;
            neg_q <= sgn1 ^ sgn2;
            neg_r <= sgn1;
          end
        end
        DIV_BUSY: begin
          if (!rem_sub[32]) begin
            rem <= rem_sub[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= rem_sh[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

`else

  assign stall_req = 1'b0;
  assign div_wr    = 1'b0;
  assign div_hi    = '0;
  assign div_lo    = '0;

`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      if (div_wr) begin
        hi <= div_hi;
        lo <= div_lo;
      end else if (is_mult | is_multu) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end else if (is_mthi) begin
        hi <= ex_reg1;
      end else if (is_mtlo) begin
        lo <= ex_reg1;
      end
    end
  end

  always_comb begin
    result = '0;
    unique case (1'b1)
      is_mfhi: result = hi;
      is_mflo: result = lo;
      default: result = '0;
    endcase
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised bench for ex_muldiv against an arithmetic HI/LO model.
// Build with or without MULDIV_DIV_EN; expectations follow the build.
module tb_ex_muldiv;
  import cpu_defs::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic  clk;
  logic  rst;
  Oper_t ex_op;
  Word_t ex_reg1;
  Word_t ex_reg2;
  logic  flush;
  logic  stall_req;
  Word_t result;
  Word_t hi;
  Word_t lo;

  int vectors;
  int errors;

  Word_t m_hi;
  Word_t m_lo;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .ex_op     (ex_op),
    .ex_reg1   (ex_reg1),
    .ex_reg2   (ex_reg2),
    .flush     (flush),
    .stall_req (stall_req),
    .result    (result),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input Oper_t op,
                       input Word_t a,
                       input Word_t b);
    logic [63:0] p;
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        p = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      OP_DIV: begin
        if (DIV_EN && b != 0) begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      OP_DIVU: begin
        if (DIV_EN && b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge
  // after the op has left EX.
  task automatic exec(input Oper_t op,
                      input Word_t a,
                      input Word_t b);
    int n;
    int exp_n;
    ex_op   = op;
    ex_reg1 = a;
    ex_reg2 = b;
    flush   = 1'b0;
    #1;
    if (op == OP_MFHI || op == OP_MFLO) begin
      vectors++;
      if (result !== (op == OP_MFHI ? m_hi : m_lo)) begin
        errors++;
        $display("FAIL mf_result op=%s got=%h exp=%h",
                 op.name(), result,
                 op == OP_MFHI ? m_hi : m_lo);
      end
    end
    exp_n = (DIV_EN && (op == OP_DIV || op == OP_DIVU)
             && b != 0) ? 33 : 0;
    n = 0;
    while (stall_req === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
      #1;
    end
    vectors++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL stall_cycles op=%s got=%0d exp=%0d",
               op.name(), n, exp_n);
    end
    model(op, a, b);
    @(negedge clk);
    vectors++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL hilo op=%s a=%h b=%h got=%h/%h exp=%h/%h",
               op.name(), a, b, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    ex_op = OP_MFHI;
    #1;
    vectors++;
    if (result !== 32'h0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mfhi got=%h/%b exp=0/0",
               result, stall_req);
    end
    ex_op = OP_MFLO;
    #1;
    vectors++;
    if (result !== 32'h0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got=%h/%h/%h exp=0",
               result, hi, lo);
    end
    ex_op = OP_NOP;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    exec(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_const got=%h/%h exp=ffffffff/fffffffa",
               hi, lo);
    end
    exec(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    vectors++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL multu_const got=%h/%h exp=00000002/fffffffa",
               hi, lo);
    end
    exec(OP_MFHI, 32'h0, 32'h0);
    exec(OP_MFLO, 32'h0, 32'h0);
  endtask

  task automatic test_mt();
    exec(OP_MTHI, 32'hDEAD_BEEF, 32'h1);
    exec(OP_MTLO, 32'h1234_5678, 32'h2);
    exec(OP_MFHI, 32'h0, 32'h0);
    exec(OP_MFLO, 32'h0, 32'h0);
  endtask

  task automatic test_div();
    exec(OP_MTHI, 32'h5555_5555, 32'h0);
    exec(OP_DIVU, 32'd100, 32'd7);
    exec(OP_MFLO, 32'h0, 32'h0);
    exec(OP_MFHI, 32'h0, 32'h0);
    exec(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    exec(OP_MFHI, 32'h0, 32'h0);
    exec(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    exec(OP_MFLO, 32'h0, 32'h0);
    exec(OP_DIV, 32'h1234_5678, 32'h0);
    exec(OP_DIVU, 32'h1234_5678, 32'h0);
  endtask

  task automatic test_flush();
    exec(OP_MTHI, 32'hA5A5_0001, 32'h0);
    exec(OP_MTLO, 32'h5A5A_0002, 32'h0);
    ex_op   = OP_DIVU;
    ex_reg1 = 32'd1000;
    ex_reg2 = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got=%b exp=0", stall_req);
    end
    @(negedge clk);
    flush = 1'b0;
    ex_op = OP_NOP;
    #1;
    vectors++;
    if (hi !== m_hi || lo !== m_lo || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_hilo got=%h/%h/%b exp=%h/%h/0",
               hi, lo, stall_req, m_hi, m_lo);
    end
    @(negedge clk);
    exec(OP_DIVU, 32'd1000, 32'd3);
    // Flush landing on the write-back cycle.
    ex_op   = OP_DIVU;
    ex_reg1 = 32'hFFFF_0000;
    ex_reg2 = 32'd77;
    #1;
    for (int i = 0; i < 60 && stall_req === 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ex_op = OP_NOP;
    #1;
    vectors++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_done got=%h/%h exp=%h/%h",
               hi, lo, m_hi, m_lo);
    end
    ex_op   = OP_MULT;
    ex_reg1 = 32'd9;
    ex_reg2 = 32'd9;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ex_op = OP_NOP;
    #1;
    vectors++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_mult got=%h/%h exp=%h/%h",
               hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exec(OP_MTHI, 32'h0BAD_F00D, 32'h0);
    ex_op   = OP_DIVU;
    ex_reg1 = 32'd5000;
    ex_reg2 = 32'd13;
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got=%h/%h/%b exp=0/0/0",
               hi, lo, stall_req);
    end
    ex_op = OP_NOP;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exec(OP_DIVU, 32'd5000, 32'd13);
  endtask

  task automatic test_random();
    Oper_t ops [10];
    Oper_t op;
    Word_t a;
    Word_t b;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI,
            OP_MTLO, OP_MFHI, OP_MFLO, OP_ADD, OP_LW};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 9));
      exec(op, a, b);
    end
  endtask

  task automatic test_back_to_back();
    exec(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    exec(OP_DIV, 32'h8000_0001, 32'h0000_0010);
    exec(OP_MFHI, 32'h0, 32'h0);
    exec(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001);
    exec(OP_MFLO, 32'h0, 32'h0);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    m_hi    = '0;
    m_lo    = '0;
    rst     = 1'b0;
    flush   = 1'b0;
    ex_op   = OP_NOP;
    ex_reg1 = '0;
    ex_reg2 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mult();
    test_mt();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
